// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter that lets two masters share the single port of a 256 x 32
// synchronous data memory, issuing one registered access per grant and acknowledging it.
module data_mem_arbiter #(
    parameter int MEM_DEPTH = 256
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic        err,
    output logic [31:0] rdata,
    output logic        busy,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        MemWrite,
    output logic        MemRead,
    input  logic [31:0] mem_read_data
);

    localparam logic [31:0] DEPTH_C = 32'(MEM_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic        cmd_we_q, cmd_we_d;
    logic        cmd_err_q, cmd_err_d;
    logic [31:0] cmd_addr_q, cmd_addr_d;
    logic [31:0] cmd_wdata_q, cmd_wdata_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_we_q, mem_we_d;
    logic        mem_re_q, mem_re_d;

    logic        grant_s;
    logic        win_we_s;
    logic [31:0] win_addr_s;
    logic [31:0] win_wdata_s;

    // Full 32-bit unsigned check: anything at or above the depth is rejected.
    function automatic logic addr_in_range(input logic [31:0] a);
        return (a < DEPTH_C);
    endfunction

    // Winner selection: a tie goes to the port that was not served last.
    always_comb begin
        if (req0 && req1) begin
            grant_s = ~last_q;
        end else if (req1) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
        if (grant_s) begin
            win_we_s    = we1;
            win_addr_s  = addr1;
            win_wdata_s = wdata1;
        end else begin
            win_we_s    = we0;
            win_addr_s  = addr0;
            win_wdata_s = wdata0;
        end
    end

    // Sequencer next state and next memory-strobe values.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        cmd_we_d    = cmd_we_q;
        cmd_err_d   = cmd_err_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;
        mem_re_d    = mem_re_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    owner_d     = grant_s;
                    last_d      = grant_s;
                    cmd_we_d    = win_we_s;
                    cmd_addr_d  = win_addr_s;
                    cmd_wdata_d = win_wdata_s;
                    if (addr_in_range(win_addr_s)) begin
                        state_d     = ISSUE;
                        cmd_err_d   = 1'b0;
                        mem_addr_d  = win_addr_s;
                        mem_wdata_d = win_wdata_s;
                        mem_we_d    = win_we_s;
                        mem_re_d    = ~win_we_s;
                    end else begin
                        state_d   = RESP;
                        cmd_err_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                state_d     = RESP;
                mem_addr_d  = 32'd0;
                mem_wdata_d = 32'd0;
                mem_we_d    = 1'b0;
                mem_re_d    = 1'b0;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and command registers; reset abandons any in-flight access.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            cmd_we_q    <= 1'b0;
            cmd_err_q   <= 1'b0;
            cmd_addr_q  <= 32'd0;
            cmd_wdata_q <= 32'd0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            cmd_we_q    <= cmd_we_d;
            cmd_err_q   <= cmd_err_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
        end
    end

    // Response decode: read data only passes through for an error-free read.
    always_comb begin
        ack0  = 1'b0;
        ack1  = 1'b0;
        err   = 1'b0;
        rdata = 32'd0;
        if (state_q == RESP) begin
            ack0 = ~owner_q;
            ack1 = owner_q;
            err  = cmd_err_q;
            if (!cmd_we_q && !cmd_err_q) begin
                rdata = mem_read_data;
            end else begin
                rdata = 32'd0;
            end
        end else begin
            rdata = 32'd0;
        end
    end

    assign busy           = (state_q != IDLE);
    assign mem_address    = mem_addr_q;
    assign mem_write_data = mem_wdata_q;
    assign MemWrite       = mem_we_q;
    assign MemRead        = mem_re_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed vector table, hand sequences for reset and
// protocol corners, and randomized traffic checked against a per-cycle schedule model.
module tb_data_mem_arbiter;

    localparam logic [31:0] DB = 32'hDEAD_BEEF;
    localparam logic [31:0] P1 = 32'h1234_5678;
    localparam logic [31:0] Z  = 32'd0;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = 32'd0, addr1 = 32'd0, wdata0 = 32'd0, wdata1 = 32'd0;
    logic        ack0, ack1, err, busy, MemWrite, MemRead;
    logic [31:0] rdata, mem_address, mem_write_data;
    logic [31:0] mem_read_data = 32'd0;

    logic [31:0] tb_mem  [256];
    logic [31:0] ref_mem [256];
    logic        preload = 1'b1;
    logic        chk_en  = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;

    data_mem_arbiter #(.MEM_DEPTH(256)) dut (
        .Clk(Clk), .Reset(Reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err(err), .rdata(rdata), .busy(busy),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .MemWrite(MemWrite), .MemRead(MemRead), .mem_read_data(mem_read_data)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] init_word(input int i);
        if (i == 5) return DB;
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    // Synchronous 256 x 32 memory, registered read
    always @(posedge Clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) tb_mem[i] <= init_word(i);
        end else begin
            if (MemWrite === 1'b1) tb_mem[mem_address[7:0]] <= mem_write_data;
            if (MemRead === 1'b1) mem_read_data <= tb_mem[mem_address[7:0]];
        end
    end

    // ---------------- reference model: schedule of upcoming busy cycles ----------------
    typedef struct {
        bit          issue;
        bit          port;
        bit          we;
        bit          err;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t        mq[$];
    exp_t        mf, mr, mg;
    bit          m_last = 1'b1;
    logic        e_ack0 = 1'b0, e_ack1 = 1'b0, e_err = 1'b0, e_busy = 1'b0, e_rd = 1'b0, e_wr = 1'b0;
    logic [31:0] e_rdata = 32'd0, e_addr = 32'd0, e_wd = 32'd0;

    always @(posedge Clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        end
        if (Reset) begin
            // the strobe was already up during an ISSUE cycle, so the memory still writes
            if (mq.size() > 0 && mq[0].issue && mq[0].we) ref_mem[mq[0].addr[7:0]] = mq[0].wdata;
            mq.delete();
            m_last = 1'b1;
        end else if (mq.size() > 0) begin
            mf = mq.pop_front();
            if (mf.issue && mf.we) begin
                ref_mem[mf.addr[7:0]] = mf.wdata;
            end else if (mf.issue) begin
                mr = mq.pop_front();
                mr.rdata = ref_mem[mf.addr[7:0]];
                mq.push_front(mr);
            end
        end else if (req0 || req1) begin
            mg.port  = (req0 && req1) ? ~m_last : req1;
            m_last   = mg.port;
            mg.we    = mg.port ? we1 : we0;
            mg.addr  = mg.port ? addr1 : addr0;
            mg.wdata = mg.port ? wdata1 : wdata0;
            mg.err   = (mg.addr >= 32'd256);
            mg.rdata = 32'd0;
            if (!mg.err) begin
                mg.issue = 1'b1;
                mq.push_back(mg);
            end
            mg.issue = 1'b0;
            mq.push_back(mg);
        end
        {e_ack0, e_ack1, e_err, e_busy, e_rd, e_wr} = 6'b0;
        {e_rdata, e_addr, e_wd} = {Z, Z, Z};
        if (mq.size() > 0) begin
            e_busy = 1'b1;
            if (mq[0].issue) begin
                e_rd   = ~mq[0].we;
                e_wr   = mq[0].we;
                e_addr = mq[0].addr;
                e_wd   = mq[0].wdata;
            end else begin
                e_ack0  = ~mq[0].port;
                e_ack1  = mq[0].port;
                e_err   = mq[0].err;
                e_rdata = mq[0].rdata;
            end
        end
    end

    // Every cycle after reset: compare all outputs with the model
    always @(negedge Clk) begin
        if (chk_en) begin
            vectors++;
            if ({ack0, ack1, err, rdata, busy, MemRead, MemWrite, mem_address, mem_write_data} !==
                {e_ack0, e_ack1, e_err, e_rdata, e_busy, e_rd, e_wr, e_addr, e_wd}) begin
                miscompares++;
                $display("FAIL model t=%0t got ack0=%b ack1=%b err=%b rdata=%h busy=%b rd=%b wr=%b addr=%h wd=%h expected ack0=%b ack1=%b err=%b rdata=%h busy=%b rd=%b wr=%b addr=%h wd=%h",
                         $time, ack0, ack1, err, rdata, busy, MemRead, MemWrite, mem_address, mem_write_data,
                         e_ack0, e_ack1, e_err, e_rdata, e_busy, e_rd, e_wr, e_addr, e_wd);
            end
        end
    end

    // ---------------- directed vectors ----------------
    typedef enum logic [2:0] {E_IDLE, E_RD, E_WR, E_ACK0, E_ACK1} ek_t;

    typedef struct {
        logic        rst;
        logic        r0;
        logic        w0;
        logic [31:0] a0;
        logic [31:0] d0;
        logic        r1;
        logic        w1;
        logic [31:0] a1;
        logic [31:0] d1;
        ek_t         k;   // expected activity in the cycle after the inputs are sampled
        logic [31:0] x;   // address for E_RD/E_WR, read data for acks
        logic [31:0] y;   // write data for E_WR
        logic        e;   // expected err with an ack
    } vec_t;

    vec_t tbl [26];
    vec_t hv;

    task automatic step(input vec_t v, input string tag);
        logic        xa0, xa1, xe, xb, xr, xw;
        logic [31:0] xd, xa, xwd;
        Reset = v.rst; req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
        req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
        @(posedge Clk);
        @(negedge Clk);
        {xa0, xa1, xe, xr, xw} = 5'b0;
        {xd, xa, xwd} = {Z, Z, Z};
        xb = (v.k != E_IDLE);
        case (v.k)
            E_RD:    begin xr = 1'b1; xa = v.x; end
            E_WR:    begin xw = 1'b1; xa = v.x; xwd = v.y; end
            E_ACK0:  begin xa0 = 1'b1; xd = v.x; xe = v.e; end
            E_ACK1:  begin xa1 = 1'b1; xd = v.x; xe = v.e; end
            default: begin end
        endcase
        vectors++;
        if ({ack0, ack1, err, rdata, busy, MemRead, MemWrite, mem_address, mem_write_data} !==
            {xa0, xa1, xe, xd, xb, xr, xw, xa, xwd}) begin
            miscompares++;
            $display("FAIL %s got ack0=%b ack1=%b err=%b rdata=%h busy=%b rd=%b wr=%b addr=%h wd=%h expected ack0=%b ack1=%b err=%b rdata=%h busy=%b rd=%b wr=%b addr=%h wd=%h",
                     tag, ack0, ack1, err, rdata, busy, MemRead, MemWrite, mem_address, mem_write_data,
                     xa0, xa1, xe, xd, xb, xr, xw, xa, xwd);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 11))
            0:       return 32'd255;
            1:       return 32'd256;
            2:       return $urandom() | 32'h0000_0100;
            default: return 32'($urandom_range(0, 15));
        endcase
    endfunction

    initial begin
        // reset, single read, port-1 write/read-back, out of range
        tbl[0]  = '{1'b1, 1'b0, 1'b0, Z, Z, 1'b0, 1'b0, Z, Z, E_IDLE, Z, Z, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, Z, Z, 1'b0, 1'b0, Z, Z, E_IDLE, Z, Z, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 32'd5, Z, 1'b0, 1'b0, Z, Z, E_RD, 32'd5, Z, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 32'd5, Z, 1'b0, 1'b0, Z, Z, E_ACK0, DB, Z, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, Z, Z, 1'b0, 1'b0, Z, Z, E_IDLE, Z, Z, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, Z, Z, 1'b1, 1'b1, 32'd200, P1, E_WR, 32'd200, P1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, Z, Z, 1'b1, 1'b1, 32'd200, P1, E_ACK1, Z, Z, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, Z, Z, 1'b0, 1'b0, Z, Z, E_IDLE, Z, Z, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, Z, Z, 1'b1, 1'b0, 32'd200, Z, E_RD, 32'd200, Z, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, Z, Z, 1'b1, 1'b0, 32'd200, Z, E_ACK1, P1, Z, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, Z, Z, 1'b0, 1'b0, Z, Z, E_IDLE, Z, Z, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 32'd256, Z, 1'b0, 1'b0, Z, Z, E_ACK0, Z, Z, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 1'b0, Z, Z, 1'b0, 1'b0, Z, Z, E_IDLE, Z, Z, 1'b0};
        // contention: both requests held from reset, grants alternate starting with port 0
        tbl[13] = '{1'b1, 1'b1, 1'b0, 32'd5, Z, 1'b1, 1'b0, 32'd200, Z, E_IDLE, Z, Z, 1'b0};
        for (int i = 14; i < 25; i++) begin
            tbl[i] = '{1'b0, 1'b1, 1'b0, 32'd5, Z, 1'b1, 1'b0, 32'd200, Z, E_IDLE, Z, Z, 1'b0};
        end
        tbl[14].k = E_RD;   tbl[14].x = 32'd5;
        tbl[15].k = E_ACK0; tbl[15].x = DB;
        tbl[17].k = E_RD;   tbl[17].x = 32'd200;
        tbl[18].k = E_ACK1; tbl[18].x = P1;
        tbl[20].k = E_RD;   tbl[20].x = 32'd5;
        tbl[21].k = E_ACK0; tbl[21].x = DB;
        tbl[23].k = E_RD;   tbl[23].x = 32'd200;
        tbl[24].k = E_ACK1; tbl[24].x = P1;
        tbl[25] = '{1'b0, 1'b0, 1'b0, Z, Z, 1'b0, 1'b0, Z, Z, E_IDLE, Z, Z, 1'b0};

        @(posedge Clk);
        #1 preload = 1'b0;
        chk_en = 1'b1;
        @(negedge Clk);

        for (int i = 0; i < 26; i++) step(tbl[i], $sformatf("row%0d", i));

        vectors++;
        if (tb_mem[0] !== init_word(0)) begin
            miscompares++;
            $display("FAIL oor_mem_untouched got %h expected %h", tb_mem[0], init_word(0));
        end

        // reset during ISSUE of a write: no ack, then port 1 alone is served normally
        hv = '{1'b0, 1'b1, 1'b1, 32'd10, 32'hAAAA_5555, 1'b0, 1'b0, Z, Z, E_WR, 32'd10, 32'hAAAA_5555, 1'b0};
        step(hv, "rst_issue");
        hv = '{1'b1, 1'b1, 1'b1, 32'd10, 32'hAAAA_5555, 1'b0, 1'b0, Z, Z, E_IDLE, Z, Z, 1'b0};
        step(hv, "rst_abort");
        hv = '{1'b0, 1'b0, 1'b0, Z, Z, 1'b1, 1'b0, 32'd5, Z, E_RD, 32'd5, Z, 1'b0};
        step(hv, "rst_p1_issue");
        hv.k = E_ACK1; hv.x = DB;
        step(hv, "rst_p1_ack");
        hv = '{1'b0, 1'b0, 1'b0, Z, Z, 1'b0, 1'b0, Z, Z, E_IDLE, Z, Z, 1'b0};
        step(hv, "rst_p1_idle");

        // req0 dropped during ISSUE: ack still pulses, no second access follows
        hv = '{1'b0, 1'b1, 1'b0, 32'd5, Z, 1'b0, 1'b0, Z, Z, E_RD, 32'd5, Z, 1'b0};
        step(hv, "hold_issue");
        hv = '{1'b0, 1'b0, 1'b0, Z, Z, 1'b0, 1'b0, Z, Z, E_ACK0, DB, Z, 1'b0};
        step(hv, "hold_ack");
        hv = '{1'b0, 1'b0, 1'b0, Z, Z, 1'b0, 1'b0, Z, Z, E_IDLE, Z, Z, 1'b0};
        step(hv, "hold_idle");
        step(hv, "hold_no_second");

        // randomized protocol-abiding traffic, occasional resets
        for (int c = 0; c < 3000; c++) begin
            Reset = ($urandom_range(0, 199) == 0);
            if (req0 && e_ack0) begin
                req0 = 1'b0;
            end else if (!req0 && $urandom_range(0, 2) == 0) begin
                req0 = 1'b1; we0 = 1'($urandom_range(0, 1)); addr0 = rand_addr(); wdata0 = $urandom();
            end
            if (req1 && e_ack1) begin
                req1 = 1'b0;
            end else if (!req1 && $urandom_range(0, 2) == 0) begin
                req1 = 1'b1; we1 = 1'($urandom_range(0, 1)); addr1 = rand_addr(); wdata1 = $urandom();
            end
            @(posedge Clk);
            @(negedge Clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter and access sequencer for the 256 x 32 synchronous data memory. It lets the CPU load/store stage (port 0) and a secondary master such as a debug loader or DMA (port 1) share the memory's single read/write interface. The arbiter resolves contention round-robin, registers the winning command, and drives MemRead/MemWrite for exactly one clock. It then returns a one-cycle acknowledge with read data, or with an error for out-of-range addresses.

## Interface
- MEM_DEPTH, 256: number of 32-bit words in the data memory; valid word addresses are 0..MEM_DEPTH-1.
- Clk  input  1  system clock; all state changes on posedge.
- Reset  input  1  synchronous, active-high reset.
- req0 / req1  input  1  access request from port 0 / port 1; held high until that port's ack.
- we0 / we1  input  1  1 = write, 0 = read; stable while req is high.
- addr0 / addr1  input  32  word address; stable while req is high.
- wdata0 / wdata1  input  32  write data; stable while req is high.
- ack0 / ack1  output  1  one-cycle completion pulse for port 0 / port 1.
- err  output  1  qualifies the current ack: address out of range, no access performed.
- rdata  output  32  read data, valid only while ack0 or ack1 is high.
- busy  output  1  high whenever state is not IDLE.
- mem_address  output  32  to memory address.
- mem_write_data  output  32  to memory write_data.
- MemWrite / MemRead  output  1  to memory write / read strobes.
- mem_read_data  input  32  from memory read_data (registered inside the memory on posedge).

## Operation
- State machine with states IDLE, ISSUE and RESP. Internal registers: owner (1 bit), last (1 bit), cmd_we, cmd_addr, cmd_wdata.
- IDLE, no request: remain in IDLE.
- IDLE, exactly one request: grant it.
- IDLE, both requests: grant the port not equal to last.
- On grant:
  - Latch owner, we, addr and wdata of the winner; set last to the winner.
  - addr < MEM_DEPTH: go to ISSUE. Registered mem_address and mem_write_data take the latched values, MemWrite = we, MemRead = !we.
  - addr >= MEM_DEPTH: go directly to RESP with an error flag set; MemRead and MemWrite stay 0. The comparison is unsigned on the full 32 bits.
- ISSUE: lasts exactly one cycle. The memory performs the access on the closing edge. On that edge, MemRead, MemWrite, mem_address and mem_write_data clear to 0, and the state goes to RESP.
- RESP: lasts exactly one cycle.
  - ack[owner] = 1 and err = error flag.
  - rdata = mem_read_data for reads without error; rdata = 0 for writes and errors.
  - ack, err and rdata are decoded combinationally from state and registers.
  - Next state is IDLE. A new grant cannot occur in RESP.
- No command queueing: a request arriving during ISSUE or RESP waits in IDLE arbitration.
- A requester dropping req before its ack is a protocol violation. The latched command still completes and ack still pulses.
- Reset in any state:
  - State goes to IDLE, last = 1 so port 0 wins the first tie, and owner = 0.
  - All command registers clear.
  - All outputs are 0; an in-flight access is abandoned with no ack.
  - If reset is asserted during ISSUE, MemRead and MemWrite are 0 from the next cycle on.

## Timing
- Valid access latency: req sampled high in IDLE at edge E0. ISSUE occupies the cycle after E0, and the memory access happens at edge E1. ack and rdata are high in the cycle after E1, i.e. 2 cycles after the grant edge. Throughput is one access per 3 cycles.
- Out-of-range latency: ack with err is high in the cycle immediately after the grant edge.
- Reset values: ack0 = ack1 = err = busy = MemRead = MemWrite = 0, and rdata = mem_address = mem_write_data = 0.
- MemRead and MemWrite are never both 1. Each is high for at most one consecutive cycle per grant.
- ack0 and ack1 are never both 1.

## Test plan
- Single read: preload mem[5] = 0xDEADBEEF; req0 = 1, we0 = 0, addr0 = 5 -> MemRead high for 1 cycle with mem_address = 5; ack0 2 cycles after grant with rdata = 0xDEADBEEF, err = 0.
- Write then read-back on port 1: write 0x12345678 to address 200, then read address 200 -> ack1 twice, second rdata = 0x12345678; the write's ack shows rdata = 0.
- Contention: both req held continuously from reset -> grants alternate 0, 1, 0, 1; four acks in 12 cycles; port 0 is served first.
- Out of range: req0 with addr0 = 256 -> ack0 and err the cycle after grant; MemRead/MemWrite never asserted; memory contents unchanged.
- Reset mid-access: assert Reset during ISSUE of a write -> no ack; all outputs 0 the next cycle; after release, req1 alone is granted normally.
- Protocol hold: req0 dropped during ISSUE -> ack0 still pulses in RESP; no spurious second access.
